// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and op-field bit positions.
package md_pkg;

    localparam logic [1:0] MD_MULTU = 2'b00;
    localparam logic [1:0] MD_MULT  = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_DIV   = 2'b11;

    localparam int OP_SIGNED_BIT = 0;
    localparam int OP_DIV_BIT    = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_t;

endpackage

// File: rtl/md_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module md_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             next_bit,
    output logic [WIDTH:0]   new_rem,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             unused_rem_msb;

    // The incoming remainder is always below the divisor, so its MSB is zero.
    assign unused_rem_msb = rem[WIDTH];

    // NOTE: combinational blocks assign every output on every path, so no latch is inferred.
    always_comb begin
        shifted = {rem[WIDTH-1:0], next_bit};
        diff    = {1'b0, shifted} - {2'b00, divisor};
        q_bit   = ~diff[WIDTH+1];
        new_rem = q_bit ? diff[WIDTH:0] : shifted;
    end

endmodule

// File: rtl/md_iter_unit.sv
// Iterative WIDTH-generic multiply/divide unit with start/valid/annul handshake.
// Optional feature: define MD_FAST_MUL_EN for a single-cycle multiply path.
module md_iter_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    input  logic             annul_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_zero_o
);

    localparam int W2 = 2 * WIDTH;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               dz;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [W2-1:0]      acc;
    logic [WIDTH:0]     rem;

    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     step_rem;
    logic               step_q;
    logic [WIDTH:0]     mul_sum;
    logic [W2-1:0]      prod_s;
    logic [WIDTH-1:0]   quot_s, rem_s;

    always_comb begin
        sign_a  = op_i[OP_SIGNED_BIT] & opa_i[WIDTH-1];
        sign_b  = op_i[OP_SIGNED_BIT] & opb_i[WIDTH-1];
        abs_a   = sign_a ? -opa_i : opa_i;
        abs_b   = sign_b ? -opb_i : opb_i;
        mul_sum = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
        prod_s  = neg_res ? -acc : acc;
        quot_s  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_s   = neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    end

    // Divide keeps the dividend in acc's low half; quotient bits shift in behind it.
    md_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .divisor  (b_mag),
        .next_bit (acc[WIDTH-1]),
        .new_rem  (step_rem),
        .q_bit    (step_q)
    );

    assign busy_o = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            is_div     <= 1'b0;
            neg_res    <= 1'b0;
            neg_rem    <= 1'b0;
            dz         <= 1'b0;
            a_mag      <= '0;
            b_mag      <= '0;
            acc        <= '0;
            rem        <= '0;
            valid_o    <= 1'b0;
            hi_o       <= '0;
            lo_o       <= '0;
            div_zero_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (annul_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (start_i) begin
                        is_div  <= op_i[OP_DIV_BIT];
                        neg_res <= sign_a ^ sign_b;
                        neg_rem <= sign_a;
                        dz      <= op_i[OP_DIV_BIT] && (opb_i == '0);
                        // On divide-by-zero a_mag carries the raw dividend for hi_o.
                        a_mag   <= (op_i[OP_DIV_BIT] && (opb_i == '0)) ? opa_i : abs_a;
                        b_mag   <= abs_b;
                        acc     <= {{WIDTH{1'b0}}, op_i[OP_DIV_BIT] ? abs_a : abs_b};
                        rem     <= '0;
                        cnt     <= CNT_W'(WIDTH);
                        state   <= CALC;
                    end
                    CALC: begin
                        if (dz) begin
                            state <= SIGN;
                        end
`ifdef MD_FAST_MUL_EN
                        else if (!is_div) begin
                            acc   <= W2'(a_mag) * W2'(b_mag);
                            state <= SIGN;
                        end
`endif
                        else begin
                            cnt <= cnt - CNT_W'(1);
                            if (is_div) begin
                                acc[WIDTH-1:0] <= {acc[WIDTH-2:0], step_q};
                                rem            <= step_rem;
                            end else begin
                                acc <= {mul_sum, acc[WIDTH-1:1]};
                            end
                            if (cnt == CNT_W'(1)) state <= SIGN;
                        end
                    end
                    SIGN: begin
                        if (dz) begin
                            hi_o       <= a_mag;
                            lo_o       <= '1;
                            div_zero_o <= 1'b1;
                        end else if (is_div) begin
                            hi_o       <= rem_s;
                            lo_o       <= quot_s;
                            div_zero_o <= 1'b0;
                        end else begin
                            hi_o       <= prod_s[W2-1:WIDTH];
                            lo_o       <= prod_s[WIDTH-1:0];
                            div_zero_o <= 1'b0;
                        end
                        valid_o <= 1'b1;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
